// File: rtl/gin_tag_sequencer.sv
// -----------------------------------------------------------------------------
// gin_tag_sequencer
//
// Upstream feeder of the GIN bus. Takes an untagged word stream read from the
// GLB and attaches a {row,col} multicast tag to each word, following a
// row/col/word schedule that is latched when a start pulse is accepted. Tagged
// words leave through a one-deep registered valid/ready output stage. The
// module runs one schedule per accepted start and pulses done once the last
// tagged word has left.
//
// Ports
//   i_clk, i_rst     clock (rising edge) and synchronous active-high reset
//   i_start          start pulse; accepted only in IDLE with a legal cfg
//   i_cfg_rows       row tags in the schedule        (1..ROW_NUM)
//   i_cfg_cols       col tags per row                (1..COL_NUM)
//   i_cfg_words      words per {row,col} pair        (nonzero)
//   o_busy           high while not IDLE
//   o_done           one-cycle pulse after the final output handshake
//   i_data/i_valid/o_ready          upstream (GLB) word stream
//   o_data/o_valid/i_ready          tagged word stream to GIN bus
//   o_tag_row/o_tag_col             tag travelling with o_data
// -----------------------------------------------------------------------------
module gin_tag_sequencer #(
  parameter int DATA_BITWIDTH = 16,
  parameter int ROW_NUM       = 6,
  parameter int COL_NUM       = 6,
  parameter int TAG_BITWIDTH  = 3,
  parameter int WORD_BITWIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [TAG_BITWIDTH-1:0]  i_cfg_rows,
  input  logic [TAG_BITWIDTH-1:0]  i_cfg_cols,
  input  logic [WORD_BITWIDTH-1:0] i_cfg_words,
  output logic                     o_busy,
  output logic                     o_done,
  input  logic [DATA_BITWIDTH-1:0] i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [DATA_BITWIDTH-1:0] o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [TAG_BITWIDTH-1:0]  o_tag_row,
  output logic [TAG_BITWIDTH-1:0]  o_tag_col
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [TAG_BITWIDTH-1:0]  ROW_MAX  = TAG_BITWIDTH'(ROW_NUM);
  localparam logic [TAG_BITWIDTH-1:0]  COL_MAX  = TAG_BITWIDTH'(COL_NUM);
  localparam logic [TAG_BITWIDTH-1:0]  TAG_ONE  = TAG_BITWIDTH'(1);
  localparam logic [WORD_BITWIDTH-1:0] WORD_ONE = WORD_BITWIDTH'(1);

  state_t                   state_q;

  // Latched schedule
  logic [TAG_BITWIDTH-1:0]  cfg_rows_q;
  logic [TAG_BITWIDTH-1:0]  cfg_cols_q;
  logic [WORD_BITWIDTH-1:0] cfg_words_q;

  // Position of the next word to be accepted: r outermost, w innermost
  logic [TAG_BITWIDTH-1:0]  r_q, r_d;
  logic [TAG_BITWIDTH-1:0]  c_q, c_d;
  logic [WORD_BITWIDTH-1:0] w_q, w_d;

  // Output stage
  logic [DATA_BITWIDTH-1:0] data_q;
  logic [TAG_BITWIDTH-1:0]  tag_row_q;
  logic [TAG_BITWIDTH-1:0]  tag_col_q;
  logic                     valid_q;
  logic                     done_q;

  logic cfg_legal;
  logic ready_w;
  logic in_hs;
  logic out_hs;
  logic w_last;
  logic c_last;
  logic r_last;
  logic sched_last;

  assign cfg_legal = (i_cfg_rows  != '0) && (i_cfg_rows <= ROW_MAX) &&
                     (i_cfg_cols  != '0) && (i_cfg_cols <= COL_MAX) &&
                     (i_cfg_words != '0);

  // Upstream may push whenever the output slot is empty or is being emptied
  // in this same cycle; this gives full throughput with a single register.
  assign ready_w = (state_q == S_RUN) && (!valid_q || i_ready);
  assign in_hs   = i_valid && ready_w;
  assign out_hs  = valid_q && i_ready;

  assign w_last     = (w_q == cfg_words_q - WORD_ONE);
  assign c_last     = (c_q == cfg_cols_q  - TAG_ONE);
  assign r_last     = (r_q == cfg_rows_q  - TAG_ONE);
  assign sched_last = w_last && c_last && r_last;

  // Counter advance for one accepted word. Past the final word r overflows,
  // which is harmless: the FSM leaves RUN and a new start clears everything.
  always_comb begin
    w_d = w_q + WORD_ONE;
    c_d = c_q;
    r_d = r_q;
    if (w_last) begin
      w_d = '0;
      if (c_last) begin
        c_d = '0;
        r_d = r_q + TAG_ONE;
      end else begin
        c_d = c_q + TAG_ONE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cfg_rows_q  <= '0;
      cfg_cols_q  <= '0;
      cfg_words_q <= '0;
      r_q         <= '0;
      c_q         <= '0;
      w_q         <= '0;
      data_q      <= '0;
      tag_row_q   <= '0;
      tag_col_q   <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (i_start && cfg_legal) begin
            cfg_rows_q  <= i_cfg_rows;
            cfg_cols_q  <= i_cfg_cols;
            cfg_words_q <= i_cfg_words;
            r_q         <= '0;
            c_q         <= '0;
            w_q         <= '0;
            state_q     <= S_RUN;
          end
        end
        S_RUN: begin
          if (in_hs) begin
            r_q <= r_d;
            c_q <= c_d;
            w_q <= w_d;
            if (sched_last) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // The final word is still in the output register; finish only
          // once it has been taken by the bus.
          if (out_hs) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      // Output register: a load wins over a simultaneous unload, so the
      // slot stays full and the replaced word is the one just handed off.
      if (in_hs) begin
        data_q    <= i_data;
        tag_row_q <= r_q;
        tag_col_q <= c_q;
        valid_q   <= 1'b1;
      end else if (out_hs) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign o_ready   = ready_w;
  assign o_busy    = (state_q != S_IDLE);
  assign o_done    = done_q;
  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_tag_row = tag_row_q;
  assign o_tag_col = tag_col_q;

endmodule

// File: tb/tb_gin_tag_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gin_tag_sequencer
//
// Directed bench for gin_tag_sequencer. Inputs are driven 1 time unit after
// the rising edge; outputs are observed on the falling edge. A monitor records
// every output handshake, done pulse and stall-hold violation; the main
// sequence compares those records against tag/data sequences it derives from
// the configured schedule.
// -----------------------------------------------------------------------------
module tb_gin_tag_sequencer;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic [2:0]  i_cfg_rows;
  logic [2:0]  i_cfg_cols;
  logic [7:0]  i_cfg_words;
  logic        o_busy;
  logic        o_done;
  logic [15:0] i_data;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] o_data;
  logic        o_valid;
  logic        i_ready;
  logic [2:0]  o_tag_row;
  logic [2:0]  o_tag_col;

  gin_tag_sequencer #(
    .DATA_BITWIDTH (16),
    .ROW_NUM       (6),
    .COL_NUM       (6),
    .TAG_BITWIDTH  (3),
    .WORD_BITWIDTH (8)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_cfg_rows  (i_cfg_rows),
    .i_cfg_cols  (i_cfg_cols),
    .i_cfg_words (i_cfg_words),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_tag_row   (o_tag_row),
    .o_tag_col   (o_tag_col)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int vectors    = 0;
  int miscompares = 0;

  // Monitor records
  logic [15:0] q_data[$];
  logic [2:0]  q_row[$];
  logic [2:0]  q_col[$];
  int mcyc          = 0;
  int last_hs_cyc   = 0;
  int done_cyc      = 0;
  int done_cnt      = 0;
  int done_busy_err = 0;
  int stall_err     = 0;
  bit prev_stall    = 0;
  logic [15:0] p_data;
  logic [2:0]  p_row;
  logic [2:0]  p_col;

  always @(negedge i_clk) begin
    mcyc++;
    if (i_rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && (o_valid !== 1'b1 || o_data !== p_data ||
                         o_tag_row !== p_row || o_tag_col !== p_col))
        stall_err++;
      if (o_valid && i_ready) begin
        q_data.push_back(o_data);
        q_row.push_back(o_tag_row);
        q_col.push_back(o_tag_col);
        last_hs_cyc = mcyc;
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = mcyc;
        if (o_busy) done_busy_err++;
      end
      prev_stall = o_valid && !i_ready;
      p_data = o_data;
      p_row  = o_tag_row;
      p_col  = o_tag_col;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_records();
    q_data.delete();
    q_row.delete();
    q_col.delete();
  endtask

  task automatic do_start(input int rows, input int cols, input int words);
    @(posedge i_clk); #1;
    i_start     = 1'b1;
    i_cfg_rows  = 3'(rows);
    i_cfg_cols  = 3'(cols);
    i_cfg_words = 8'(words);
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  // Feed `total` words starting at value `base`. Optional random valid
  // bubbles and a 1,0,0,1 i_ready stall pattern. With wait_done the task
  // runs until a new done pulse is seen; otherwise it returns right after
  // the cycle in which the last word is offered and will be accepted.
  task automatic stream(input string tag, input int total, input int base,
                        input bit rnd_valid, input bit stall_ready, input bit wait_done);
    int sent  = 0;
    int cyc   = 0;
    int d0    = done_cnt;
    int limit = total * 8 + 100;
    bit fin   = 0;
    while (!fin && cyc < limit) begin
      @(posedge i_clk); #1;
      i_valid = (sent < total) && (!rnd_valid || ($urandom_range(0, 1) == 1));
      i_data  = 16'(base + sent);
      i_ready = !stall_ready || (cyc % 4 == 0) || (cyc % 4 == 3);
      @(negedge i_clk); #1;
      if (i_valid && o_ready) sent++;
      cyc++;
      fin = wait_done ? (done_cnt > d0) : (sent == total);
    end
    chk({tag, "_timeout"}, 32'(fin), 32'd1);
    if (wait_done) begin
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      i_ready = 1'b1;
    end
  endtask

  task automatic check_seq(input string tag, input int rows, input int cols,
                           input int words, input int base);
    int n = rows * cols * words;
    int m;
    chk({tag, "_count"}, 32'(q_data.size()), 32'(n));
    m = (q_data.size() < n) ? q_data.size() : n;
    for (int i = 0; i < m; i++) begin
      int p = i / words;
      chk($sformatf("%s_data[%0d]", tag, i), 32'(q_data[i]), 32'(16'(base + i)));
      chk($sformatf("%s_row[%0d]", tag, i),  32'(q_row[i]),  32'(p / cols));
      chk($sformatf("%s_col[%0d]", tag, i),  32'(q_col[i]),  32'(p % cols));
    end
  endtask

  initial begin
    int d0;
    i_rst       = 1'b1;
    i_start     = 1'b0;
    i_cfg_rows  = '0;
    i_cfg_cols  = '0;
    i_cfg_words = '0;
    i_data      = '0;
    i_valid     = 1'b0;
    i_ready     = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_ready", 32'(o_ready), 0);
    chk("rst_busy",  32'(o_busy),  0);
    chk("rst_done",  32'(o_done),  0);
    chk("rst_data",  32'(o_data),  0);
    chk("rst_row",   32'(o_tag_row), 0);
    chk("rst_col",   32'(o_tag_col), 0);
    i_rst = 1'b0;

    // 1: 2x3x2, always valid and ready
    clear_records();
    d0 = done_cnt;
    do_start(2, 3, 2);
    chk("t1_busy", 32'(o_busy), 1);
    stream("t1", 12, 16'h0100, 0, 0, 1);
    check_seq("t1", 2, 3, 2, 16'h0100);
    chk("t1_done_lat",  32'(done_cyc - last_hs_cyc), 1);
    chk("t1_done_cnt",  32'(done_cnt - d0), 1);
    chk("t1_done_busy", 32'(done_busy_err), 0);
    chk("t1_idle_busy", 32'(o_busy), 0);
    chk("t1_idle_ready", 32'(o_ready), 0);

    // 2: 1x2x4 with i_ready 1,0,0,1 stalls
    clear_records();
    d0 = done_cnt;
    do_start(1, 2, 4);
    stream("t2", 8, 16'h0200, 0, 1, 1);
    check_seq("t2", 1, 2, 4, 16'h0200);
    chk("t2_stall_hold", 32'(stall_err), 0);
    chk("t2_done_lat",   32'(done_cyc - last_hs_cyc), 1);
    chk("t2_done_cnt",   32'(done_cnt - d0), 1);

    // 3: same as 1 with random valid bubbles
    clear_records();
    d0 = done_cnt;
    do_start(2, 3, 2);
    stream("t3", 12, 16'h0100, 1, 0, 1);
    check_seq("t3", 2, 3, 2, 16'h0100);
    chk("t3_done_cnt", 32'(done_cnt - d0), 1);

    // 4: illegal starts ignored, start during RUN ignored
    clear_records();
    d0 = done_cnt;
    do_start(0, 3, 2);
    chk("t4_rows0_busy", 32'(o_busy), 0);
    do_start(2, 7, 2);
    chk("t4_cols7_busy", 32'(o_busy), 0);
    do_start(7, 3, 2);
    chk("t4_rows7_busy", 32'(o_busy), 0);
    do_start(2, 3, 0);
    chk("t4_words0_busy", 32'(o_busy), 0);
    repeat (3) @(posedge i_clk);
    #1;
    chk("t4_no_done", 32'(done_cnt - d0), 0);
    chk("t4_no_out",  32'(q_data.size()), 0);
    do_start(1, 2, 2);
    do_start(2, 2, 3);
    chk("t4_run_busy", 32'(o_busy), 1);
    stream("t4", 4, 16'h0400, 0, 0, 1);
    check_seq("t4", 1, 2, 2, 16'h0400);
    chk("t4_done_cnt", 32'(done_cnt - d0), 1);
    repeat (3) @(posedge i_clk);
    #1;
    chk("t4_idle_after", 32'(o_busy), 0);

    // 5: reset after the 5th input handshake aborts the schedule
    clear_records();
    d0 = done_cnt;
    do_start(2, 3, 2);
    stream("t5a", 5, 16'h0500, 0, 0, 0);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_rst   = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    chk("t5_rst_valid", 32'(o_valid), 0);
    chk("t5_rst_busy",  32'(o_busy),  0);
    chk("t5_rst_done",  32'(o_done),  0);
    repeat (2) @(posedge i_clk);
    #1;
    chk("t5_no_done", 32'(done_cnt - d0), 0);
    clear_records();
    do_start(2, 3, 2);
    stream("t5b", 12, 16'h0600, 0, 0, 1);
    check_seq("t5", 2, 3, 2, 16'h0600);
    chk("t5_done_cnt", 32'(done_cnt - d0), 1);

    // 6: largest schedule 6x6x255
    clear_records();
    d0 = done_cnt;
    do_start(6, 6, 255);
    stream("t6", 9180, 16'h1000, 0, 0, 1);
    check_seq("t6", 6, 6, 255, 16'h1000);
    if (q_data.size() > 0) begin
      chk("t6_last_row", 32'(q_row[q_row.size()-1]), 5);
      chk("t6_last_col", 32'(q_col[q_col.size()-1]), 5);
    end else begin
      chk("t6_last_present", 32'(q_data.size()), 9180);
    end
    repeat (4) @(posedge i_clk);
    #1;
    chk("t6_done_cnt",  32'(done_cnt - d0), 1);
    chk("t6_done_lat",  32'(done_cyc - last_hs_cyc), 1);
    chk("t6_done_busy", 32'(done_busy_err), 0);
    chk("t6_stall_hold", 32'(stall_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
